multicycle_controller: RTL and testbench

//  Moore-FSM control unit for the multicycle MIPS datapath (shared memory, single ALU, IR/MDR/A/B/ALUOut regs).

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 40 ++++
 rtl/multicycle_controller.sv | 175 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    // FSM state encoding; values 12..15 are unused and recover to FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU control codes driven to the datapath.
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operation class chosen by the FSM, refined by the ALU decoder.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Per-state control bundle. alu_en gates alu_control so states that
    // do not use the ALU present 000 rather than a stale add code.
    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_en;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_sig_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU operation class plus the R-type funct field onto the
// 3-bit ALU control code. Unknown funct values fall back to add and are
// flagged so the FSM can report them.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    logic [2:0] funct_ctl;

    // Decode funct independently of alu_op so the illegal flag is usable in DECODE.
    always_comb begin
        funct_ctl     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FUNCT_ADD: funct_ctl = ALU_ADD;
            FUNCT_SUB: funct_ctl = ALU_SUB;
            FUNCT_AND: funct_ctl = ALU_AND;
            FUNCT_OR:  funct_ctl = ALU_OR;
            FUNCT_SLT: funct_ctl = ALU_SLT;
            default:   funct_illegal = 1'b1;
        endcase
    end

    // Select the final ALU code from the operation class.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_ADD:   alu_control = ALU_ADD;
            ALU_OP_SUB:   alu_control = ALU_SUB;
            ALU_OP_FUNCT: alu_control = funct_ctl;
            default:      alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore FSM control unit for the multicycle MIPS datapath. Each instruction
// walks FETCH -> DECODE -> execute/writeback states; every datapath enable
// and select is a function of the current state, except alu_control (funct
// in EXECUTE) and pc_en (zero flag in BRANCH). Reset forces all outputs low.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter bit SUPPORT_ADDI = 1'b1,
    parameter bit SUPPORT_J    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t    state;
    state_t    state_next;
    ctrl_sig_t ctrl;
    logic      decode_illegal;
    logic [2:0] dec_alu_control;
    logic      funct_illegal;

    alu_decoder u_alu_decoder (
        .alu_op        (ctrl.alu_op),
        .funct         (funct),
        .alu_control   (dec_alu_control),
        .funct_illegal (funct_illegal)
    );

    // State register; reset restarts at FETCH and abandons any instruction.
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    // Next-state logic and the DECODE-only illegal opcode/funct flag.
    always_comb begin
        state_next     = S_FETCH;
        decode_illegal = 1'b0;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        // Unknown funct still completes as an add so no X escapes.
                        state_next     = S_EXECUTE;
                        decode_illegal = funct_illegal;
                    end
                    OP_BEQ:  state_next = S_BRANCH;
                    OP_ADDI: begin
                        if (SUPPORT_ADDI) state_next = S_ADDIEX;
                        else              decode_illegal = 1'b1;
                    end
                    OP_J: begin
                        if (SUPPORT_J) state_next = S_JUMP;
                        else           decode_illegal = 1'b1;
                    end
                    default: decode_illegal = 1'b1;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Per-state control bundle (Moore outputs before reset gating).
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                ctrl.alu_en    = 1'b1;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                ctrl.alu_src_b = 2'b11;
                ctrl.alu_en    = 1'b1;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
                ctrl.alu_en    = 1'b1;
                ctrl.alu_op    = ALU_OP_ADD;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b00;
                ctrl.alu_en    = 1'b1;
                ctrl.alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_en    = 1'b1;
                ctrl.alu_op    = ALU_OP_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = 2'b01;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = 2'b10;
            end
            default: ctrl = '0;
        endcase
    end

    // Drive ports; while reset is high every output is held at zero.
    always_comb begin
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        pc_src      = 2'b00;
        illegal_op  = 1'b0;
        state_o     = 4'd0;
        if (!reset) begin
            pc_en       = ctrl.pc_write | (ctrl.branch & zero);
            iord        = ctrl.iord;
            mem_write   = ctrl.mem_write;
            ir_write    = ctrl.ir_write;
            reg_dst     = ctrl.reg_dst;
            mem_to_reg  = ctrl.mem_to_reg;
            reg_write   = ctrl.reg_write;
            alu_src_a   = ctrl.alu_src_a;
            alu_src_b   = ctrl.alu_src_b;
            alu_control = ctrl.alu_en ? dec_alu_control : 3'b000;
            pc_src      = ctrl.pc_src;
            illegal_op  = decode_illegal;
            state_o     = state;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Two instances share inputs: one
// with addi/j decoded, one with both disabled. Each cycle the driver pushes
// the hand-derived output word for both instances; a monitor on the falling
// edge pops and compares.
module tb_multicycle_controller;

    // Output word: {state, pc_en, iord, mem_write, ir_write, reg_dst,
    //               mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_control,
    //               pc_src, illegal_op}
    function automatic logic [19:0] pk(input logic [3:0] st, input logic pe, input logic io,
                                       input logic mw, input logic iw, input logic rd,
                                       input logic m2r, input logic rw, input logic asa,
                                       input logic [1:0] asb, input logic [2:0] ac,
                                       input logic [1:0] ps, input logic il);
        return {st, pe, io, mw, iw, rd, m2r, rw, asa, asb, ac, ps, il};
    endfunction

    localparam logic [19:0] E_RST     = 20'd0;
    localparam logic [19:0] E_FETCH   = pk(4'd0, 1, 0, 0, 1, 0, 0, 0, 0, 2'b01, 3'b010, 2'b00, 0);
    localparam logic [19:0] E_DEC     = pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 0);
    localparam logic [19:0] E_DEC_ILL = pk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b010, 2'b00, 1);
    localparam logic [19:0] E_MEMADR  = pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
    localparam logic [19:0] E_MEMRD   = pk(4'd3, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [19:0] E_MEMWB   = pk(4'd4, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [19:0] E_MEMWR   = pk(4'd5, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [19:0] E_ALUWB   = pk(4'd7, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [19:0] E_BR_Z1   = pk(4'd8, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0);
    localparam logic [19:0] E_BR_Z0   = pk(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b110, 2'b01, 0);
    localparam logic [19:0] E_ADDIEX  = pk(4'd9, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b010, 2'b00, 0);
    localparam logic [19:0] E_ADDIWB  = pk(4'd10, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0);
    localparam logic [19:0] E_JUMP    = pk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0);

    function automatic logic [19:0] e_exec(input logic [2:0] ac);
        return pk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, ac, 2'b00, 0);
    endfunction

    // Clock and reset
    logic clk = 1'b0;
    logic reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic zero;
    always #5 clk = ~clk;

    // DUT outputs
    logic       pc_en1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1, reg_write1, alu_src_a1, illegal_op1;
    logic [1:0] alu_src_b1, pc_src1;
    logic [2:0] alu_control1;
    logic [3:0] state_o1;
    logic       pc_en2, iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2, reg_write2, alu_src_a2, illegal_op2;
    logic [1:0] alu_src_b2, pc_src2;
    logic [2:0] alu_control2;
    logic [3:0] state_o2;

    multicycle_controller #(.SUPPORT_ADDI(1'b1), .SUPPORT_J(1'b1)) dut_full (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en1), .iord(iord1), .mem_write(mem_write1), .ir_write(ir_write1),
        .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1), .reg_write(reg_write1),
        .alu_src_a(alu_src_a1), .alu_src_b(alu_src_b1), .alu_control(alu_control1),
        .pc_src(pc_src1), .illegal_op(illegal_op1), .state_o(state_o1)
    );

    multicycle_controller #(.SUPPORT_ADDI(1'b0), .SUPPORT_J(1'b0)) dut_min (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_en(pc_en2), .iord(iord2), .mem_write(mem_write2), .ir_write(ir_write2),
        .reg_dst(reg_dst2), .mem_to_reg(mem_to_reg2), .reg_write(reg_write2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_control(alu_control2),
        .pc_src(pc_src2), .illegal_op(illegal_op2), .state_o(state_o2)
    );

    logic [19:0] obs1, obs2;
    assign obs1 = {state_o1, pc_en1, iord1, mem_write1, ir_write1, reg_dst1, mem_to_reg1,
                   reg_write1, alu_src_a1, alu_src_b1, alu_control1, pc_src1, illegal_op1};
    assign obs2 = {state_o2, pc_en2, iord2, mem_write2, ir_write2, reg_dst2, mem_to_reg2,
                   reg_write2, alu_src_a2, alu_src_b2, alu_control2, pc_src2, illegal_op2};

    // Scoreboard
    logic [19:0] exp_q1[$];
    logic [19:0] exp_q2[$];
    string       tag_q[$];
    int n_pass  = 0;
    int n_total = 0;

    // Monitor: compare both instances once per cycle, away from the rising edge.
    always @(negedge clk) begin
        logic [19:0] e1, e2;
        string t;
        if (exp_q1.size() > 0) begin
            e1 = exp_q1.pop_front();
            e2 = exp_q2.pop_front();
            t  = tag_q.pop_front();
            n_total++;
            if (obs1 === e1) n_pass++;
            else $display("FAIL %s dut_full: got %05h expected %05h", t, obs1, e1);
            n_total++;
            if (obs2 === e2) n_pass++;
            else $display("FAIL %s dut_min: got %05h expected %05h", t, obs2, e2);
        end
    end

    // Driver tasks
    task automatic cyc(input string t, input logic [19:0] e1, input logic [19:0] e2);
        exp_q1.push_back(e1);
        exp_q2.push_back(e2);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // One reset cycle, then present a new instruction starting at FETCH.
    task automatic start(input logic [5:0] o, input logic [5:0] f, input logic z);
        reset = 1'b1;
        op    = o;
        funct = f;
        zero  = z;
        cyc("reset_gap", E_RST, E_RST);
        reset = 1'b0;
    endtask

    logic [5:0] r_funct [5];
    logic [2:0] r_code  [5];

    // Stimulus
    initial begin
        r_funct = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        r_code  = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_hold", E_RST, E_RST);

        // lw: five cycles, register write only in the last
        start(6'b100011, 6'h3f, 1'b0);
        cyc("lw_fetch",  E_FETCH,  E_FETCH);
        cyc("lw_decode", E_DEC,    E_DEC);
        cyc("lw_memadr", E_MEMADR, E_MEMADR);
        cyc("lw_memrd",  E_MEMRD,  E_MEMRD);
        cyc("lw_memwb",  E_MEMWB,  E_MEMWB);
        cyc("lw_return", E_FETCH,  E_FETCH);

        // sw: four cycles
        start(6'b101011, 6'h3f, 1'b0);
        cyc("sw_fetch",  E_FETCH,  E_FETCH);
        cyc("sw_decode", E_DEC,    E_DEC);
        cyc("sw_memadr", E_MEMADR, E_MEMADR);
        cyc("sw_memwr",  E_MEMWR,  E_MEMWR);
        cyc("sw_return", E_FETCH,  E_FETCH);

        // R-type, every supported funct
        for (int i = 0; i < 5; i++) begin
            start(6'b000000, r_funct[i], 1'b0);
            cyc("r_fetch",  E_FETCH, E_FETCH);
            cyc("r_decode", E_DEC,   E_DEC);
            cyc("r_exec",   e_exec(r_code[i]), e_exec(r_code[i]));
            cyc("r_aluwb",  E_ALUWB, E_ALUWB);
            cyc("r_return", E_FETCH, E_FETCH);
        end

        // R-type with unknown funct: flagged, still completes as add
        start(6'b000000, 6'b000000, 1'b0);
        cyc("rbad_fetch",  E_FETCH,     E_FETCH);
        cyc("rbad_decode", E_DEC_ILL,   E_DEC_ILL);
        cyc("rbad_exec",   e_exec(3'b010), e_exec(3'b010));
        cyc("rbad_aluwb",  E_ALUWB,     E_ALUWB);

        // beq taken and not taken
        start(6'b000100, 6'h3f, 1'b1);
        cyc("beq1_fetch",  E_FETCH, E_FETCH);
        cyc("beq1_decode", E_DEC,   E_DEC);
        cyc("beq1_branch", E_BR_Z1, E_BR_Z1);
        cyc("beq1_return", E_FETCH, E_FETCH);
        start(6'b000100, 6'h3f, 1'b0);
        cyc("beq0_fetch",  E_FETCH, E_FETCH);
        cyc("beq0_decode", E_DEC,   E_DEC);
        cyc("beq0_branch", E_BR_Z0, E_BR_Z0);
        cyc("beq0_return", E_FETCH, E_FETCH);

        // Unsupported opcode: one-cycle illegal pulse, straight back to FETCH
        start(6'b111111, 6'h3f, 1'b0);
        cyc("ill_fetch",  E_FETCH,   E_FETCH);
        cyc("ill_decode", E_DEC_ILL, E_DEC_ILL);
        cyc("ill_return", E_FETCH,   E_FETCH);

        // addi: supported on dut_full, illegal on dut_min
        start(6'b001000, 6'h3f, 1'b0);
        cyc("addi_fetch",  E_FETCH,  E_FETCH);
        cyc("addi_decode", E_DEC,    E_DEC_ILL);
        cyc("addi_c3",     E_ADDIEX, E_FETCH);
        cyc("addi_c4",     E_ADDIWB, E_DEC_ILL);
        cyc("addi_c5",     E_FETCH,  E_FETCH);

        // j: JUMP on dut_full; dut_min refetches (FETCH's own PC increment only)
        start(6'b000010, 6'h3f, 1'b0);
        cyc("j_fetch",  E_FETCH, E_FETCH);
        cyc("j_decode", E_DEC,   E_DEC_ILL);
        cyc("j_c3",     E_JUMP,  E_FETCH);
        cyc("j_c4",     E_FETCH, E_DEC_ILL);

        // Reset held for two cycles starting in EXECUTE: no ALUWB write follows
        start(6'b000000, 6'b100000, 1'b0);
        cyc("rst_fetch",  E_FETCH, E_FETCH);
        cyc("rst_decode", E_DEC,   E_DEC);
        reset = 1'b1;
        cyc("rst_in_exec", E_RST, E_RST);
        cyc("rst_hold2",   E_RST, E_RST);
        reset = 1'b0;
        cyc("rst_refetch", E_FETCH, E_FETCH);
        cyc("rst_decode2", E_DEC,   E_DEC);
        cyc("rst_exec2",   e_exec(3'b010), e_exec(3'b010));
        cyc("rst_aluwb2",  E_ALUWB, E_ALUWB);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q1.size() > 0; i++) @(negedge clk);
        if (exp_q1.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q1.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
